// File: rtl/axil_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AXI-Lite transaction out,
// exactly one response back (watchdog-bounded).
module axil_lite_master #(
    parameter int unsigned TIMEOUT = 32'd256
) (
    input  logic        M_AXI_ACLK,
    input  logic        M_AXI_ARESETN,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_write,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        rsp_timeout,
    output logic [31:0] M_AXI_AWADDR,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    output logic [31:0] M_AXI_WDATA,
    output logic [3:0]  M_AXI_WSTRB,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,
    input  logic [1:0]  M_AXI_BRESP,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY,
    output logic [31:0] M_AXI_ARADDR,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WA   = 3'd1;
    localparam logic [2:0] ST_WB   = 3'd2;
    localparam logic [2:0] ST_RA   = 3'd3;
    localparam logic [2:0] ST_RD   = 3'd4;
    localparam logic [2:0] ST_RSP  = 3'd5;
    localparam int unsigned CW = (TIMEOUT > 32'd1) ? $clog2(TIMEOUT + 32'd1) : 1;

    logic [2:0]    state_q, state_d;
    logic          init_q;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic          awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic          aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [CW-1:0] wd_q, wd_d;
    logic          rsp_write_q, rsp_write_d, rsp_timeout_q, rsp_timeout_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]    rsp_resp_q, rsp_resp_d;

    logic accept_s, aw_hs_s, w_hs_s, aw_all_s, w_all_s, busy_s, wd_hit_s, abort_s;

    // init_q keeps cmd_ready low until the first edge after reset release
    assign cmd_ready = init_q && (state_q == ST_IDLE);
    assign accept_s  = cmd_valid && cmd_ready;
    assign aw_hs_s   = awvalid_q && M_AXI_AWREADY;
    assign w_hs_s    = wvalid_q && M_AXI_WREADY;
    assign aw_all_s  = aw_done_q || aw_hs_s;
    assign w_all_s   = w_done_q || w_hs_s;
    assign busy_s    = (state_q == ST_WA) || (state_q == ST_WB) ||
                       (state_q == ST_RA) || (state_q == ST_RD);
    assign wd_hit_s  = (TIMEOUT != 32'd0) && (wd_q == CW'(TIMEOUT - 32'd1));

    // Watchdog counter: cleared on accept, saturating while a transaction is in flight
    always_comb begin
        wd_d = wd_q;
        if (accept_s) begin
            wd_d = '0;
        end else if (busy_s && (wd_q != CW'(TIMEOUT))) begin
            wd_d = wd_q + CW'(1);
        end else begin
            wd_d = wd_q;
        end
    end

    // Transaction FSM; completion is checked before the watchdog so it wins a tie
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        rsp_write_d   = rsp_write_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        abort_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    addr_d        = cmd_addr;
                    rsp_timeout_d = 1'b0;
                    if (cmd_write) begin
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = ST_WA;
                    end else begin
                        state_d   = ST_RA;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WA: begin
                awvalid_d = awvalid_q && !aw_hs_s;
                wvalid_d  = wvalid_q && !w_hs_s;
                aw_done_d = aw_all_s;
                w_done_d  = w_all_s;
                if (aw_all_s && w_all_s) begin
                    state_d = ST_WB;
                end else begin
                    abort_s = wd_hit_s;
                end
            end
            ST_WB: begin
                if (M_AXI_BVALID) begin
                    rsp_resp_d  = M_AXI_BRESP;
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = 32'h0000_0000;
                    state_d     = ST_RSP;
                end else begin
                    abort_s = wd_hit_s;
                end
            end
            ST_RA: begin
                if (M_AXI_ARREADY) begin
                    state_d = ST_RD;
                end else begin
                    abort_s = wd_hit_s;
                end
            end
            ST_RD: begin
                if (M_AXI_RVALID) begin
                    rsp_resp_d  = M_AXI_RRESP;
                    rsp_rdata_d = M_AXI_RDATA;
                    rsp_write_d = 1'b0;
                    state_d     = ST_RSP;
                end else begin
                    abort_s = wd_hit_s;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RSP;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
            end
        endcase
        if (abort_s) begin
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            rsp_timeout_d = 1'b1;
            rsp_resp_d    = 2'b10;
            rsp_rdata_d   = 32'h0000_0000;
            rsp_write_d   = (state_q == ST_WA) || (state_q == ST_WB);
            state_d       = ST_RSP;
        end else begin
            rsp_timeout_d = rsp_timeout_d;
        end
    end

    // State and datapath registers
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q       <= ST_IDLE;
            init_q        <= 1'b0;
            addr_q        <= 32'h0000_0000;
            wdata_q       <= 32'h0000_0000;
            wstrb_q       <= 4'h0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            wd_q          <= '0;
            rsp_write_q   <= 1'b0;
            rsp_rdata_q   <= 32'h0000_0000;
            rsp_resp_q    <= 2'b00;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            init_q        <= 1'b1;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
            wd_q          <= wd_d;
            rsp_write_q   <= rsp_write_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_ARVALID = (state_q == ST_RA);
    assign M_AXI_BREADY  = (state_q == ST_WB);
    assign M_AXI_RREADY  = (state_q == ST_RD);
    assign rsp_valid     = (state_q == ST_RSP);
    assign rsp_write     = rsp_write_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_timeout   = rsp_timeout_q;

endmodule

// File: tb/tb_axil_lite_master.sv
// Directed bench for axil_lite_master with a small behavioural AXI-Lite register slave.
module tb_axil_lite_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = 32'h0, cmd_wdata = 32'h0;
    logic [3:0]  cmd_wstrb = 4'h0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_write, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    always #5 clk = ~clk;

    axil_lite_master #(.TIMEOUT(32'd16)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    // ---------------- behavioural slave: regs at 0x000 and 0x010 ----------------
    int          aw_delay = 0, w_delay = 0;
    logic        ar_en = 1'b1, b_en = 1'b1;
    int          aw_wait, w_wait;
    logic        s_aw_q, s_w_q, s_ar_q, s_bvalid, s_rvalid;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [3:0]  s_wstrb;
    logic [31:0] reg0 = 32'h0, reg10 = 32'h0;
    logic        aw_have, w_have, wr_fire;
    logic [31:0] eff_addr, eff_data;
    logic [3:0]  eff_strb;

    assign awready  = (aw_wait >= aw_delay);
    assign wready   = (w_wait >= w_delay);
    assign arready  = ar_en;
    assign aw_have  = s_aw_q || (awvalid && awready);
    assign w_have   = s_w_q || (wvalid && wready);
    assign eff_addr = s_aw_q ? s_awaddr : awaddr;
    assign eff_data = s_w_q ? s_wdata : wdata;
    assign eff_strb = s_w_q ? s_wstrb : wstrb;
    assign wr_fire  = rst_n && aw_have && w_have && b_en;
    assign bvalid   = s_bvalid;
    assign bresp    = 2'b00;
    assign rvalid   = s_rvalid;
    assign rdata    = s_rdata;
    assign rresp    = 2'b00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_aw_q <= 1'b0; s_w_q <= 1'b0; s_ar_q <= 1'b0;
            s_bvalid <= 1'b0; s_rvalid <= 1'b0; aw_wait <= 0; w_wait <= 0;
            s_awaddr <= 32'h0; s_wdata <= 32'h0; s_wstrb <= 4'h0;
            s_araddr <= 32'h0; s_rdata <= 32'h0;
        end else begin
            if (awvalid && awready) s_awaddr <= awaddr;
            if (wvalid && wready) begin s_wdata <= wdata; s_wstrb <= wstrb; end
            aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
            w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
            if (wr_fire) begin
                s_bvalid <= 1'b1; s_aw_q <= 1'b0; s_w_q <= 1'b0;
            end else begin
                s_aw_q <= aw_have; s_w_q <= w_have;
                if (s_bvalid && bready) s_bvalid <= 1'b0;
            end
            if (arvalid && arready) begin s_ar_q <= 1'b1; s_araddr <= araddr; end
            else if (s_ar_q) s_ar_q <= 1'b0;
            if (s_ar_q) begin
                s_rvalid <= 1'b1;
                s_rdata  <= (s_araddr == 32'h0) ? reg0 : (s_araddr == 32'h10) ? reg10 : 32'h0;
            end else if (s_rvalid && rready) begin
                s_rvalid <= 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (wr_fire) begin
            for (int b = 0; b < 4; b++) begin
                if (eff_strb[b] && eff_addr == 32'h0)  reg0[8*b +: 8]  <= eff_data[8*b +: 8];
                if (eff_strb[b] && eff_addr == 32'h10) reg10[8*b +: 8] <= eff_data[8*b +: 8];
            end
        end
    end

    // ---------------- monitors (cycle stamps and VALID-high counters) ----------------
    int cyc = 0, acc_cyc = 0, cons_cyc = 0, aw_hs_cyc = 0, w_hs_cyc = 0;
    int awv_cnt = 0, wv_cnt = 0, arv_cnt = 0, b_early = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cmd_valid && cmd_ready) acc_cyc <= cyc;
        if (rsp_valid && rsp_ready) cons_cyc <= cyc;
        if (awvalid && awready) aw_hs_cyc <= cyc;
        if (wvalid && wready) w_hs_cyc <= cyc;
        if (awvalid) awv_cnt <= awv_cnt + 1;
        if (wvalid) wv_cnt <= wv_cnt + 1;
        if (arvalid) arv_cnt <= arv_cnt + 1;
        if (bready && (awvalid || wvalid)) b_early <= b_early + 1;
    end

    // ---------------- checking helpers ----------------
    int checks = 0, failures = 0;
    logic        r_write, r_to;
    logic [31:0] r_rdata;
    logic [1:0]  r_resp;
    int          lat;
    int          base_aw, base_w, base_ar;
    logic        stable;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        int n = 0;
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        if (!cmd_ready) chk("cmd_accept_bound", 32'd0, 32'd1);
        base_aw = awv_cnt; base_w = wv_cnt; base_ar = arv_cnt;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid && n < 100) begin tick(); n++; end
        if (!rsp_valid) chk("rsp_wait_bound", 32'd0, 32'd1);
        lat = cyc - acc_cyc;
        r_write = rsp_write; r_rdata = rsp_rdata; r_resp = rsp_resp; r_to = rsp_timeout;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        #3;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_axi_valids", {27'd0, awvalid, wvalid, arvalid, bready, rready}, 32'd0);
        chk("rst_rsp", {28'd0, rsp_valid, rsp_write, rsp_timeout, |rsp_resp}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_awaddr", awaddr, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk("release_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
        tick();
        chk("release_cmd_ready_high", {31'd0, cmd_ready}, 32'd1);

        // zero-wait write then readback
        send_cmd(1'b1, 32'h000, 32'h2, 4'hF);
        wait_rsp();
        chk("wr0_aw_hs_cyc", aw_hs_cyc - acc_cyc, 32'd1);
        chk("wr0_w_hs_cyc", w_hs_cyc - acc_cyc, 32'd1);
        chk("wr0_latency", lat, 32'd3);
        chk("wr0_rsp", {27'd0, r_write, r_to, r_resp, 1'b0}, {27'd0, 1'b1, 1'b0, 2'b00, 1'b0});
        chk("wr0_rdata", r_rdata, 32'd0);
        consume();
        chk("wr0_slave_reg0", reg0, 32'h2);

        send_cmd(1'b0, 32'h000, 32'h0, 4'h0);
        wait_rsp();
        chk("rd0_latency", lat, 32'd4);
        chk("rd0_rdata", r_rdata, 32'h0000_0002);
        chk("rd0_rsp", {29'd0, r_write, r_resp}, 32'd0);
        consume();

        // WREADY held off 5 cycles
        w_delay = 5;
        send_cmd(1'b1, 32'h010, 32'hDEAD_BEEF, 4'hF);
        wait_rsp();
        chk("skw_aw_valid_cycles", awv_cnt - base_aw, 32'd1);
        chk("skw_w_valid_cycles", wv_cnt - base_w, 32'd6);
        chk("skw_w_hs_cyc", w_hs_cyc - acc_cyc, 32'd6);
        chk("skw_latency", lat, 32'd8);
        consume();
        w_delay = 0;
        send_cmd(1'b0, 32'h010, 32'h0, 4'h0);
        wait_rsp();
        chk("skw_readback", r_rdata, 32'hDEAD_BEEF);
        consume();

        // AWREADY held off 5 cycles, partial strobe
        aw_delay = 5;
        send_cmd(1'b1, 32'h010, 32'h0BAD_F00D, 4'b0011);
        wait_rsp();
        chk("rev_aw_valid_cycles", awv_cnt - base_aw, 32'd6);
        chk("rev_w_valid_cycles", wv_cnt - base_w, 32'd1);
        chk("rev_latency", lat, 32'd8);
        consume();
        aw_delay = 0;
        send_cmd(1'b0, 32'h010, 32'h0, 4'h0);
        wait_rsp();
        chk("rev_readback", r_rdata, 32'hDEAD_F00D);
        consume();
        chk("bready_before_write_done", b_early, 32'd0);

        // watchdog abort on a read that never sees ARREADY
        ar_en = 1'b0;
        send_cmd(1'b0, 32'h000, 32'h0, 4'h0);
        wait_rsp();
        chk("wdog_arvalid_cycles", arv_cnt - base_ar, 32'd16);
        chk("wdog_latency", lat, 32'd17);
        chk("wdog_rsp", {28'd0, r_to, r_write, r_resp}, {28'd0, 1'b1, 1'b0, 2'b10});
        chk("wdog_rdata", r_rdata, 32'd0);
        chk("wdog_arvalid_low", {31'd0, arvalid}, 32'd0);
        consume();
        ar_en = 1'b1;
        send_cmd(1'b0, 32'h000, 32'h0, 4'h0);
        wait_rsp();
        chk("post_wdog_read", {r_to, r_resp, r_rdata[28:0]}, {1'b0, 2'b00, 29'h2});
        consume();

        // response backpressure with the next command already offered
        send_cmd(1'b1, 32'h010, 32'h1111_1111, 4'hF);
        wait_rsp();
        cmd_write = 1'b0; cmd_addr = 32'h010; cmd_valid = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            stable = stable && rsp_valid && !cmd_ready && (rsp_write === r_write) &&
                     (rsp_rdata === r_rdata) && (rsp_resp === r_resp) && (rsp_timeout === r_to);
            tick();
        end
        chk("bp_rsp_stable", {31'd0, stable}, 32'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tick();
        cmd_valid = 1'b0;
        chk("bp_accept_after_consume", acc_cyc - cons_cyc, 32'd1);
        wait_rsp();
        chk("bp_read_data", r_rdata, 32'h1111_1111);
        consume();

        // reset while waiting for BVALID
        b_en = 1'b0;
        send_cmd(1'b1, 32'h000, 32'h5, 4'hF);
        tick();
        chk("mid_bready_in_wb", {31'd0, bready}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outputs", {26'd0, awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 32'd0);
        chk("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        b_en = 1'b1;
        tick();
        chk("mid_post_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        send_cmd(1'b1, 32'h010, 32'h0000_0077, 4'hF);
        wait_rsp();
        chk("mid_fresh_write", {lat[7:0], 21'd0, r_write, r_resp}, {8'd3, 21'd0, 1'b1, 2'b00});
        consume();
        chk("mid_reg0_untouched", reg0, 32'h2);
        chk("mid_reg10_written", reg10, 32'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axil_lite_master.md
# axil_lite_master

Single-outstanding AXI4-Lite initiator that turns a simple command/response handshake into AXI-Lite write and read transactions. It is the host-side driver for the accelerator's AXI-Lite register slave: run/matw/last control at 0x000, dummy register at 0x010. It is used in integration benches and in on-chip sequencers that program the accelerator without a CPU. A watchdog guarantees that every accepted command produces exactly one response.

## Interface

Parameters:
- `TIMEOUT`, default 256: cycles allowed from command accept to transaction completion. 0 disables the watchdog.

Ports:
- `M_AXI_ACLK` in 1: the only clock.
- `M_AXI_ARESETN` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when high with `cmd_valid`.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in 32: byte address.
- `cmd_wdata` in 32: write data.
- `cmd_wstrb` in 4: write byte strobes.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: response consumed when high with `rsp_valid`.
- `rsp_write` out 1: response belongs to a write.
- `rsp_rdata` out 32: read data. 0 for writes and for timeouts.
- `rsp_resp` out 2: BRESP/RRESP, or 2'b10 on timeout.
- `rsp_timeout` out 1: watchdog abort.
- `M_AXI_AWADDR` out 32, `M_AXI_AWVALID` out 1, `M_AXI_AWREADY` in 1
- `M_AXI_WDATA` out 32, `M_AXI_WSTRB` out 4, `M_AXI_WVALID` out 1, `M_AXI_WREADY` in 1
- `M_AXI_BRESP` in 2, `M_AXI_BVALID` in 1, `M_AXI_BREADY` out 1
- `M_AXI_ARADDR` out 32, `M_AXI_ARVALID` out 1, `M_AXI_ARREADY` in 1
- `M_AXI_RDATA` in 32, `M_AXI_RRESP` in 2, `M_AXI_RVALID` in 1, `M_AXI_RREADY` out 1

## Operation

States and their outputs:
- IDLE: `cmd_ready`=1.
- WA: write address/data phase.
- WB: `BREADY`=1.
- RA: `ARVALID`=1.
- RD: `RREADY`=1.
- RSP: `rsp_valid`=1.

Transitions:
- IDLE, on `cmd_valid` with `cmd_write`=1:
  - Register addr/data/strb.
  - Set `AWVALID`=`WVALID`=1.
  - Go to WA.
- IDLE, on `cmd_valid` with `cmd_write`=0:
  - Register addr.
  - Set `ARVALID`=1.
  - Go to RA.
- WA:
  - Each of AW and W drops its VALID the cycle after its own handshake.
  - Sticky `aw_done` and `w_done` flags record completion.
  - When both are done, counting the current cycle's handshakes (same-cycle AW+W is allowed), go to WB.
  - `BREADY` is never asserted in WA.
- WB, on `BVALID`: capture `BRESP`, set `rsp_write`=1, `rsp_rdata`=0, then go to RSP.
- RA, on `ARREADY`: drop `ARVALID`, then go to RD.
- RD, on `RVALID`: capture `RDATA`/`RRESP`, set `rsp_write`=0, then go to RSP.
- RSP: hold all `rsp_*` stable until `rsp_ready`, then go to IDLE.
- Commands are never accepted outside IDLE. One transaction is outstanding at a time.
- Address and data outputs hold their registered values while the matching VALID is high. VALID never drops before its handshake except on timeout.

Watchdog:
- Counter is cleared on command accept.
- It increments every cycle in WA/WB/RA/RD and saturates at `TIMEOUT`.
- If it reaches `TIMEOUT`-1 with the completing handshake absent that cycle, the block aborts:
  - All AXI VALID/READY outputs are forced to 0.
  - `rsp_timeout`=1, `rsp_resp`=2'b10, `rsp_rdata`=0, `rsp_write`=command type.
  - The next state is RSP.
- If completion and timeout coincide, completion wins.
- `rsp_timeout` is cleared on the next command accept.

## Timing

- Reset (asynchronous assert, synchronous release):
  - State is IDLE.
  - Every AXI VALID/READY output is 0.
  - All `rsp_*` outputs are 0.
  - AXI address/data/strobe outputs are 0.
  - `cmd_ready` is 0 while `M_AXI_ARESETN`=0 and 1 from the first edge after release.
- Reset mid-transaction drops every VALID immediately and discards the response.
- Command accepted on edge N: AW/W/AR VALID is high from N+1.
- Against a zero-wait slave:
  - Write: AW/W handshake at N+1, `BREADY` at N+2; a slave with BVALID at N+2 gives `rsp_valid` at N+3.
  - Read: AR handshake at N+1, `RREADY` from N+2; a slave with RVALID at N+3 gives `rsp_valid` at N+4.
- Back-to-back throughput:
  - A response consumed on edge M allows a new command to be accepted on edge M+1.
  - There is no combinational path from `rsp_ready` to `cmd_ready`.
- All outputs are registered or decoded from state only. There are no combinational paths from AXI inputs to AXI outputs.

## Test plan

- **Write to zero-wait register slave:** write 0x000 ← 0x2 with `wstrb`=0xF -> AW/W handshake the same cycle; `rsp_valid` 3 cycles after accept with `rsp_resp`=0, `rsp_write`=1; slave run=1.
- **Read back after the write:** read 0x000 -> `rsp_rdata`=0x00000002, `rsp_resp`=0, `rsp_valid` 4 cycles after accept.
- **Skewed write handshakes:**
  - Stimulus: hold `WREADY` low 5 cycles with `AWREADY`=1 (then the reverse case), writing 0x010 ← 0xDEADBEEF.
  - Response: AWVALID drops after 1 cycle; WVALID stays until its handshake; `BREADY` only asserts after both; the readback of 0x010 gives 0xDEADBEEF.
- **Watchdog abort:** `TIMEOUT`=16, slave never asserts `ARREADY` -> `ARVALID` drops after 16 cycles; `rsp_timeout`=1, `rsp_resp`=2'b10, `rsp_rdata`=0; the next command succeeds normally.
- **Response backpressure:** hold `rsp_ready`=0 for 10 cycles with `cmd_valid` continuously high -> `rsp_*` stable, `cmd_ready`=0 throughout; the next command is accepted 1 cycle after the `rsp_ready` pulse.
- **Reset mid-transaction:** assert `M_AXI_ARESETN`=0 while in WB -> `BREADY`, `rsp_valid` and all VALIDs go to 0 asynchronously; after release `cmd_ready`=1 and a fresh write completes.
